// File: rtl/beea_modinv_pkg.sv
// Shared ALU definitions for the binary extended Euclidean modular-inverse engine.
package beea_modinv_pkg;

  localparam int DEFAULT_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    HALVE_U = 3'd2,
    HALVE_V = 3'd3,
    SUB     = 3'd4,
    FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/beea_halve.sv
// Halving step: x shifted right, y halved modulo odd p (adds p first when y is odd).
module beea_halve
  import beea_modinv_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] p,
  output logic [W-1:0] x_half,
  output logic [W-1:0] y_half
);

  logic [W:0] sum;

  // Extra bit keeps the carry of y+p so the halved value stays exact.
  assign sum    = {1'b0, y} + {1'b0, p};
  assign x_half = x >> 1;
  assign y_half = y[0] ? W'(sum >> 1) : (y >> 1);

endmodule

// File: rtl/beea_modinv.sv
// Modular inverse k^-1 mod p via binary extended Euclid; start/done handshake, err on bad operands.
module beea_modinv
  import beea_modinv_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] k,
  input  logic [W-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  state_t       state_reg;
  logic [W-1:0] u_reg;
  logic [W-1:0] v_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] c_reg;
  logic [W-1:0] p_reg;
  logic         force_err_reg;
  logic         done_reg;
  logic [W-1:0] result_reg;
  logic         err_reg;

  logic [W-1:0] u_half;
  logic [W-1:0] a_half;
  logic [W-1:0] v_half;
  logic [W-1:0] c_half;

  logic         invalid;
  logic         u_ge_v;
  logic [W-1:0] u_diff;
  logic [W-1:0] v_diff;
  logic [W-1:0] a_sub;
  logic [W-1:0] c_sub;

  beea_halve #(.W(W)) halve_ua (
    .x      (u_reg),
    .y      (a_reg),
    .p      (p_reg),
    .x_half (u_half),
    .y_half (a_half)
  );

  beea_halve #(.W(W)) halve_vc (
    .x      (v_reg),
    .y      (c_reg),
    .p      (p_reg),
    .x_half (v_half),
    .y_half (c_half)
  );

  // u still holds k while in CHECK.
  assign invalid = !p_reg[0] || (p_reg < W'(3)) || (u_reg == '0) || (u_reg >= p_reg);

  // a and c live in [0,p_r), so one conditional add of p_r restores the range.
  assign u_ge_v = u_reg >= v_reg;
  assign u_diff = u_reg - v_reg;
  assign v_diff = v_reg - u_reg;
  assign a_sub  = (a_reg >= c_reg) ? (a_reg - c_reg) : (a_reg - c_reg + p_reg);
  assign c_sub  = (c_reg >= a_reg) ? (c_reg - a_reg) : (c_reg - a_reg + p_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      u_reg         <= '0;
      v_reg         <= '0;
      a_reg         <= '0;
      c_reg         <= '0;
      p_reg         <= '0;
      force_err_reg <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            u_reg         <= k;
            v_reg         <= p;
            a_reg         <= W'(1);
            c_reg         <= '0;
            p_reg         <= p;
            force_err_reg <= 1'b0;
            state_reg     <= CHECK;
          end
        end
        CHECK: begin
          if (invalid) begin
            force_err_reg <= 1'b1;
            state_reg     <= FINISH;
          end else begin
            state_reg <= HALVE_U;
          end
        end
        HALVE_U: begin
          if (!u_reg[0]) begin
            u_reg <= u_half;
            a_reg <= a_half;
          end else begin
            state_reg <= HALVE_V;
          end
        end
        HALVE_V: begin
          if (!v_reg[0]) begin
            v_reg <= v_half;
            c_reg <= c_half;
          end else begin
            state_reg <= SUB;
          end
        end
        SUB: begin
          if (u_ge_v) begin
            u_reg     <= u_diff;
            a_reg     <= a_sub;
            state_reg <= (u_diff == '0) ? FINISH : HALVE_U;
          end else begin
            v_reg     <= v_diff;
            c_reg     <= c_sub;
            state_reg <= HALVE_U;
          end
        end
        FINISH: begin
          done_reg <= 1'b1;
          if ((v_reg == W'(1)) && !force_err_reg) begin
            result_reg <= c_reg;
            err_reg    <= 1'b0;
          end else begin
            result_reg <= '0;
            err_reg    <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = state_reg != IDLE;
  assign done   = done_reg;
  assign result = result_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_beea_modinv.sv
// Self-checking bench for beea_modinv: directed table, handshake corner cases, random vs. extended-Euclid model.
module tb_beea_modinv;

  logic        clk;
  logic        rst;
  logic        start32;
  logic [31:0] k32;
  logic [31:0] p32;
  logic        busy32;
  logic        done32;
  logic [31:0] result32;
  logic        err32;
  logic        start8;
  logic [7:0]  k8;
  logic [7:0]  p8;
  logic        busy8;
  logic        done8;
  logic [7:0]  result8;
  logic        err8;

  int checks   = 0;
  int failures = 0;

  beea_modinv #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .k(k32), .p(p32),
    .busy(busy32), .done(done32), .result(result32), .err(err32)
  );

  beea_modinv #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .k(k8), .p(p8),
    .busy(busy8), .done(done8), .result(result8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;      // 1 = 8-bit instance
    logic [31:0] k;
    logic [31:0] p;
    logic [31:0] exp_res;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: classic (division-based) extended Euclid on signed integers.
  task automatic ref_inv(input longint kk, input longint pp, output longint r, output bit e);
    longint old_r, cur_r, old_s, cur_s, q, t;
    if ((pp % 2 == 0) || (pp < 3) || (kk == 0) || (kk >= pp)) begin
      r = 0; e = 1'b1;
    end else begin
      old_r = kk; cur_r = pp; old_s = 1; cur_s = 0;
      while (cur_r != 0) begin
        q = old_r / cur_r;
        t = old_r - q * cur_r; old_r = cur_r; cur_r = t;
        t = old_s - q * cur_s; old_s = cur_s; cur_s = t;
      end
      if (old_r != 1) begin
        r = 0; e = 1'b1;
      end else begin
        r = ((old_s % pp) + pp) % pp; e = 1'b0;
      end
    end
  endtask

  function automatic int limit_of(input bit sel);
    return sel ? (8 * 8 + 4) : (8 * 32 + 4);
  endfunction

  // lat counts the start-sampling edge as 1.
  task automatic run_op(input bit sel, input logic [31:0] kk, input logic [31:0] pp,
                        output logic [31:0] res, output logic e, output logic b,
                        output int lat, output bit to);
    @(negedge clk);
    if (sel) begin k8 = kk[7:0]; p8 = pp[7:0]; start8 = 1'b1; end
    else begin k32 = kk; p32 = pp; start32 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    lat = 1;
    while (!(sel ? done8 : done32) && lat < limit_of(sel)) begin
      @(posedge clk); #1;
      lat++;
    end
    to  = !(sel ? done8 : done32);
    res = sel ? {24'd0, result8} : result32;
    e   = sel ? err8 : err32;
    b   = sel ? busy8 : busy32;
  endtask

  task automatic run_and_check(input string tag, input bit sel, input logic [31:0] kk,
                               input logic [31:0] pp, input logic [31:0] er, input bit ee,
                               input bit check_lat3);
    logic [31:0] res;
    logic e, b;
    int lat;
    bit to;
    run_op(sel, kk, pp, res, e, b, lat, to);
    check({tag, "_timeout"}, to, 0);
    check({tag, "_result"}, res, er);
    check({tag, "_err"}, e, ee);
    check({tag, "_busy_at_done"}, b, 0);
    if (check_lat3) check({tag, "_latency"}, lat, 3);
    else check({tag, "_latency_bound"}, (lat <= limit_of(sel)), 1);
    $display("op %s W=%0d k=%0h p=%0h -> result=%0h err=%0b lat=%0d", tag, sel ? 8 : 32, kk, pp, res, e, lat);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] res, kk, pp;
    logic e, b;
    int lat, cnt;
    bit to;
    longint rr;
    bit re;

    vecs[0] = '{0, 32'd3,  32'd7,          32'd5,          0};
    vecs[1] = '{0, 32'd1,  32'd7,          32'd1,          0};
    vecs[2] = '{0, 32'd10, 32'd11,         32'd10,         0};
    vecs[3] = '{0, 32'd2,  32'hFFFF_FFFB,  32'h7FFF_FFFE,  0};
    vecs[4] = '{1, 32'd2,  32'd251,        32'd126,        0};
    vecs[5] = '{1, 32'd6,  32'd9,          32'd0,          1};
    vecs[6] = '{0, 32'd3,  32'd8,          32'd0,          1};
    vecs[7] = '{0, 32'd0,  32'd7,          32'd0,          1};
    vecs[8] = '{0, 32'd7,  32'd7,          32'd0,          1};
    vecs[9] = '{1, 32'd1,  32'd1,          32'd0,          1};

    rst = 1'b1; start32 = 1'b0; start8 = 1'b0;
    k32 = '0; p32 = '0; k8 = '0; p8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy32, 0);
    check("reset_done", done32, 0);
    check("reset_result", result32, 0);
    check("reset_err", err32, 0);
    check("reset_busy8", busy8, 0);
    @(negedge clk); rst = 1'b0;

    // Directed table; operand-check failures must finish in exactly 3 edges.
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].k, vecs[i].p,
                    vecs[i].exp_res, vecs[i].exp_err, (i >= 6));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), vecs[i].sel ? done8 : done32, 0);
    end

    // Start pulsed while busy must be ignored.
    @(negedge clk); k32 = 32'd3; p32 = 32'd7; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    @(negedge clk);
    check("ignore_busy_high", busy32, 1);
    k32 = 32'd1; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 300) begin @(posedge clk); #1; lat++; end
    check("ignore_timeout", done32, 1);
    check("ignore_result", result32, 5);
    check("ignore_busy_at_done", busy32, 0);
    $display("op ignore_start W=32 k=3 p=7 -> result=%0h err=%0b", result32, err32);

    // Start during the done cycle is accepted.
    run_op(0, 32'd10, 32'd11, res, e, b, lat, to);
    check("b2b_first_result", res, 10);
    start32 = 1'b1; k32 = 32'd1; p32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("b2b_accepted_busy", busy32, 1);
    lat = 0;
    while (!done32 && lat < 300) begin @(posedge clk); #1; lat++; end
    check("b2b_second_result", result32, 1);
    check("b2b_second_err", err32, 0);
    $display("op back_to_back W=32 k=1 p=7 -> result=%0h err=%0b", result32, err32);

    // Reset mid-operation clears outputs and suppresses done.
    @(negedge clk); k32 = 32'd2; p32 = 32'hFFFF_FFFB; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy32, 0);
    check("midrst_done", done32, 0);
    check("midrst_result", result32, 0);
    check("midrst_err", err32, 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done32) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_and_check("after_rst", 0, 32'd3, 32'd7, 32'd5, 0, 0);

    // Random W=32: odd moduli, k mostly in range.
    for (int i = 0; i < 30; i++) begin
      pp = $urandom | 32'd1;
      if (pp < 3) pp = 32'd3;
      kk = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, pp - 1);
      ref_inv(longint'(kk), longint'(pp), rr, re);
      run_and_check($sformatf("rnd32_%0d", i), 0, kk, pp, 32'(rr), re, 0);
    end

    // Random W=8: any operands, so gcd>1 and invalid cases show up often.
    for (int i = 0; i < 40; i++) begin
      pp = 32'($urandom_range(0, 255));
      kk = 32'($urandom_range(0, 255));
      ref_inv(longint'(kk), longint'(pp), rr, re);
      run_and_check($sformatf("rnd8_%0d", i), 1, kk, pp, 32'(rr), re, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
